muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: op_valid  in  1  EX-stage instruction is a HI/LO-class op.
REQ-004 SHALL have ports: op  in  3  operation code, encodings from muldiv_pkg (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-005 SHALL have ports: src_a  in  32  rs value (dividend/multiplicand/MTxx data).
REQ-006 SHALL have ports: src_b  in  32  rt value (divisor/multiplier).
REQ-007 SHALL have ports: cancel  in  1  exception/ERET flush of EX stage.
REQ-008 SHALL have ports: busy  out  1  pipeline stall request, combinational.
REQ-009 SHALL have ports: done  out  1  one-cycle result-written pulse.
REQ-010 SHALL have ports: hi_out  out  32  architectural HI register.
REQ-011 SHALL have ports: lo_out  out  32  architectural LO register.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL accept an op only in IDLE with op_valid=1 and cancel=0; operands and op latched on the accepting edge.
REQ-014 SHALL, for MULT/MULTU accepted, go IDLE->MUL->DONE, writing the 64-bit product {HI,LO} on the MUL->DONE edge.
REQ-015 SHALL, for DIV/DIVU accepted, go IDLE->DIV, remain in DIV exactly 32 cycles (5-bit counter 0..31, one radix-2 restoring step per cycle), write LO=quotient, HI=remainder on the counter==31 edge, then go to DONE.
REQ-016 SHALL, for signed DIV, divide magnitudes; quotient negated iff src_a[31]^src_b[31]; remainder takes sign of src_a.
REQ-017 SHALL, for divisor zero (signed or unsigned), write LO=32'hFFFFFFFF and HI=src_a, with the same 32-cycle latency.
REQ-018 SHALL, for MTHI/MTLO accepted, write HI or LO with src_a on the accepting edge, stay in IDLE, never assert busy or done.
REQ-019 SHALL drive busy = (IDLE & op_valid & op in {MULT,MULTU,DIV,DIVU} & ~cancel) | MUL | DIV.
REQ-020 SHALL assert done only in DONE; DONE lasts exactly one cycle, then IDLE; op_valid ignored in DONE (held instruction retires that cycle).
REQ-021 SHALL, on cancel=1 in MUL or DIV, abort to IDLE at next edge with HI/LO unchanged and no done pulse.
REQ-022 SHALL, on cancel=1 in DONE, still return to IDLE; HI/LO already written are kept.
REQ-023 SHALL ignore op_valid in MUL/DIV; a new op is taken only from IDLE.
REQ-024 SHALL make hi_out/lo_out visible the cycle after write; no bypass of in-flight results.

Reset
REQ-025 SHALL, on resetn=0 at any time incl. mid-divide, asynchronously force state IDLE, counter 0, HI=LO=0, done=0; busy then depends only on REQ-019 IDLE term.
REQ-026 SHALL resume normal acceptance on the first rising edge after resetn deasserts.

Structure
REQ-027 SHALL take op encodings, FSM state encoding and DIV_STEPS=32 from shared package muldiv_pkg.
REQ-028 SHALL place the one-step restoring divide (partial remainder/quotient shift-subtract) in sub-module div_iter_core; FSM, counter, sign fix-up, multiplier and HI/LO registers stay in muldiv_ctrl.

Verification
REQ-029 SHALL check: MULT src_a=-3, src_b=5 -> busy 2 cycles, done on 3rd cycle, HI=FFFFFFFF, LO=FFFFFFF1.
REQ-030 SHALL check: DIVU 100/7 -> busy 33 cycles, done next cycle, LO=14, HI=2.
REQ-031 SHALL check: DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIV 7/0 -> LO=FFFFFFFF, HI=7.
REQ-032 SHALL check: DIVU started with HI=LO=5, cancel at iteration 10 -> IDLE next cycle, no done, HI=LO=5.
REQ-033 SHALL check: MTHI 0x1234 then MTLO 0xABCD back-to-back in IDLE -> busy never high, hi_out=0x1234, lo_out=0xABCD.
REQ-034 SHALL check: resetn pulsed low at DIV iteration 20 -> HI=LO=0, state IDLE, no done, busy=0 with op_valid=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op codes, FSM states,
// divide step count and a small magnitude helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_STEPS);

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// One radix-2 restoring divide step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module div_iter_core (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_shift;
  logic [32:0] w_diff;

  assign w_shift = {i_rem, i_quo[31]};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  // A non-negative difference is always below the divisor, so it fits in 32 bits.
  always_comb begin
    o_rem = w_shift[31:0];
    o_quo = {i_quo[30:0], 1'b0};
    if (!w_diff[32]) begin
      o_rem = w_diff[31:0];
      o_quo = {i_quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: single-cycle multiply, 32-step iterative divide,
// MTHI/MTLO writes, pipeline stall and cancel handling.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  op_e                r_op;
  logic [31:0]        r_a, r_b, r_rem, r_quo, r_hi, r_lo;
  logic               r_neg_q, r_neg_r;

  op_e                w_op;
  logic               w_accept, w_is_mul, w_is_div, w_last;
  logic [31:0]        w_dvsr, w_rem_nxt, w_quo_nxt, w_rem_fix, w_quo_fix;
  logic [63:0]        w_ext_a, w_ext_b, w_prod;

  assign w_op     = op_e'(op);
  assign w_accept = (r_state == StIdle) & op_valid & ~cancel;
  assign w_is_mul = (w_op == OpMult) | (w_op == OpMultu);
  assign w_is_div = (w_op == OpDiv) | (w_op == OpDivu);
  assign w_last   = (r_cnt == CNT_W'(DIV_STEPS - 1));

  // Signed divide iterates on magnitudes; signs are restored on the final write.
  assign w_dvsr    = (r_op == OpDiv) ? abs32(r_b) : r_b;
  assign w_quo_fix = r_neg_q ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
  assign w_rem_fix = r_neg_r ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

  assign w_ext_a = {{32{(r_op == OpMult) & r_a[31]}}, r_a};
  assign w_ext_b = {{32{(r_op == OpMult) & r_b[31]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  div_iter_core u_div_iter_core (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (w_dvsr),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept && w_is_mul)      w_state_nxt = StMul;
        else if (w_accept && w_is_div) w_state_nxt = StDiv;
      end
      StMul:  w_state_nxt = cancel ? StIdle : StDone;
      StDiv: begin
        if (cancel)      w_state_nxt = StIdle;
        else if (w_last) w_state_nxt = StDone;
      end
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    busy = ((r_state == StIdle) & op_valid & ~cancel & (w_is_mul | w_is_div)) |
           (r_state == StMul) | (r_state == StDiv);
    done = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_op    <= OpMult;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op    <= w_op;
            r_a     <= src_a;
            r_b     <= src_b;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= (w_op == OpDiv) ? abs32(src_a) : src_a;
            r_neg_q <= (w_op == OpDiv) & (src_a[31] ^ src_b[31]);
            r_neg_r <= (w_op == OpDiv) & src_a[31];
            if (w_op == OpMthi) r_hi <= src_a;
            if (w_op == OpMtlo) r_lo <= src_a;
          end
        end
        StMul: begin
          if (!cancel) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        StDiv: begin
          if (cancel) begin
            r_cnt <= '0;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              if (r_b == 32'd0) begin
                r_lo <= 32'hFFFF_FFFF;
                r_hi <= r_a;
              end else begin
                r_lo <= w_quo_fix;
                r_hi <= w_rem_fix;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl: multiply, divide, divide-by-zero,
// cancel, MTHI/MTLO and asynchronous reset behaviour.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5;

  muldiv_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the op until done; returns busy-cycle count and cycle index of done (-1 on timeout).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output int done_at);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    nbusy = 0; done_at = -1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (done) begin
        done_at = c;
        break;
      end
      if (busy) nbusy++;
      step();
    end
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi_out); end
    n_tests++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo_out); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    op_valid = 1'b1; op = DIV; #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_idle_term: got %b want 1", busy); end
    op_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_mult();
    int nb, da;
    run_op(MULT, 32'hFFFF_FFFD, 32'd5, nb, da);
    n_tests++; if (nb !== 2) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 2", nb); end
    n_tests++; if (da !== 2) begin n_fail++; $display("FAIL mult_done_cycle: got %0d want 2", da); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_in_done: got %b want 0", busy); end
    n_tests++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi_out); end
    n_tests++; if (lo_out !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo: got %h want fffffff1", lo_out); end
    // Cancel during DONE must keep the written result.
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_width: got %b want 0", done); end
    n_tests++; if (lo_out !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_cancel_done_lo: got %h want fffffff1", lo_out); end
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, da);
    n_tests++; if (hi_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi_out); end
    n_tests++; if (lo_out !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo_out); end
    step();
  endtask

  task automatic test_divu();
    int nb, da;
    run_op(DIVU, 32'd100, 32'd7, nb, da);
    n_tests++; if (nb !== 33) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d want 33", nb); end
    n_tests++; if (da !== 33) begin n_fail++; $display("FAIL divu_done_cycle: got %0d want 33", da); end
    n_tests++; if (lo_out !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want 0000000e", lo_out); end
    n_tests++; if (hi_out !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want 00000002", hi_out); end
    step();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL divu_done_width: got %b want 0", done); end
  endtask

  task automatic test_div_signed();
    logic [2:0]  t_op [4] = '{DIV, DIV, DIV, DIVU};
    logic [31:0] t_a  [4] = '{32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] t_b  [4] = '{32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0};
    logic [31:0] t_lo [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_hi [4] = '{32'hFFFF_FFFF, 32'd1, 32'd7, 32'hFFFF_FFF9};
    int nb, da;
    for (int i = 0; i < 4; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], nb, da);
      n_tests++;
      if (da !== 33 || lo_out !== t_lo[i] || hi_out !== t_hi[i]) begin
        n_fail++;
        $display("FAIL div_vec%0d: got done@%0d lo=%h hi=%h want done@33 lo=%h hi=%h",
                 i, da, lo_out, hi_out, t_lo[i], t_hi[i]);
      end
      step();
    end
  endtask

  task automatic test_cancel();
    int ndone;
    op_valid = 1'b1; op = MTHI; src_a = 32'd5; step();
    op = MTLO; step();
    op = DIVU; src_a = 32'd100; src_b = 32'd7; step();
    repeat (10) step();
    cancel = 1'b1; #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_in_div: got %b want 1", busy); end
    step();
    cancel = 1'b0; op_valid = 1'b0; #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b want 0", busy); end
    n_tests++; if (hi_out !== 32'd5) begin n_fail++; $display("FAIL cancel_hi: got %h want 00000005", hi_out); end
    n_tests++; if (lo_out !== 32'd5) begin n_fail++; $display("FAIL cancel_lo: got %h want 00000005", lo_out); end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      step();
    end
    n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL cancel_no_done: got %0d pulses want 0", ndone); end
    n_tests++; if (lo_out !== 32'd5) begin n_fail++; $display("FAIL cancel_lo_later: got %h want 00000005", lo_out); end
  endtask

  task automatic test_reset_mid_div();
    int ndone;
    op_valid = 1'b1; op = DIVU; src_a = 32'd1000; src_b = 32'd3; step();
    repeat (20) step();
    #2 resetn = 1'b0;
    #1 op_valid = 1'b0;
    #1;
    n_tests++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hi: got %h want 0", hi_out); end
    n_tests++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL rst_mid_lo: got %h want 0", lo_out); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    step();
    #3 resetn = 1'b1;
    step();
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) ndone++;
      step();
    end
    n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", ndone); end
  endtask

  task automatic test_mthi_mtlo();
    int nbusy;
    nbusy = 0;
    op_valid = 1'b1; op = MTHI; src_a = 32'h1234; #1;
    if (busy || done) nbusy++;
    step();
    n_tests++; if (hi_out !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi: got %h want 00001234", hi_out); end
    op = MTLO; src_a = 32'hABCD; #1;
    if (busy || done) nbusy++;
    step();
    op_valid = 1'b0; #1;
    if (busy || done) nbusy++;
    n_tests++; if (lo_out !== 32'hABCD) begin n_fail++; $display("FAIL mtlo_lo: got %h want 0000abcd", lo_out); end
    n_tests++; if (hi_out !== 32'h1234) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h want 00001234", hi_out); end
    n_tests++; if (nbusy !== 0) begin n_fail++; $display("FAIL mtxx_busy_done: got %0d cycles want 0", nbusy); end
    step();
  endtask

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0; cancel = 1'b0;
    test_reset();
    test_mult();
    test_divu();
    test_div_signed();
    test_cancel();
    test_reset_mid_div();
    test_mthi_mtlo();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
